// File: rtl/sp_ram_pkg.sv
// Shared types for the single-port RAM arbiter.
// Holds the arbiter FSM state enum, the requester port-id type and the
// byte-offset width of a 32-bit word address.
package sp_ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    localparam int WORD_OFFSET_W = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a combinational grant.
// Ports:
//   clk, rstn_i   - clock, asynchronous active-low reset
//   en_i          - arbitration enabled (no grant when low)
//   req_i[1:0]    - request per port
//   gnt_o[1:0]    - one-hot grant, same cycle as the request
//   gnt_id_o      - index of the winning port
//   gnt_valid_o   - a grant is issued this cycle
// The last-grant pointer resets to port 1 so port 0 wins the first tie.
module rr_arb2
    import sp_ram_pkg::*;
(
    input  logic       clk,
    input  logic       rstn_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output port_id_t   gnt_id_o,
    output logic       gnt_valid_o
);

    port_id_t last_r;
    port_id_t win_s;

    // Pick the winner: on a tie the port not granted most recently wins.
    always_comb begin
        win_s       = PORT0;
        gnt_o       = 2'b00;
        gnt_valid_o = en_i && (req_i != 2'b00);
        if (req_i == 2'b11) begin
            win_s = (last_r == PORT1) ? PORT0 : PORT1;
        end else if (req_i == 2'b10) begin
            win_s = PORT1;
        end else begin
            win_s = PORT0;
        end
        if (gnt_valid_o) begin
            gnt_o[win_s] = 1'b1;
        end else begin
            gnt_o = 2'b00;
        end
        gnt_id_o = win_s;
    end

    // Last-grant pointer, moves only on a granted cycle.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            last_r <= PORT1;
        end else if (gnt_valid_o) begin
            last_r <= win_s;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Two-port front end for a single-port RAM with 1-cycle read latency.
// After reset (INIT_EN=1) the RAM is zero-filled one word per cycle; then
// port 0 (core LSU) and port 1 (debug/AXI) share it under round-robin.
// Ports:
//   clk, rstn_i                 - clock, asynchronous active-low reset
//   pN_req_i/_gnt_o/_rvalid_o   - request, same-cycle grant, response strobe
//   pN_addr_i/_we_i/_be_i/_wdata_i - access attributes of port N
//   pN_rdata_o                  - read data, zero unless a read response
//   ram_*                       - single-port RAM interface
//   init_done_o                 - RAM available to requesters
module sp_ram_arbiter
    import sp_ram_pkg::*;
#(
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH = 32,
    parameter int INIT_EN    = 1
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic                    p0_req_i,
    output logic                    p0_gnt_o,
    output logic                    p0_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,
    input  logic                    p1_req_i,
    output logic                    p1_gnt_o,
    output logic                    p1_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,
    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
    output logic                    init_done_o
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = ADDR_WIDTH - WORD_OFFSET_W;
    localparam logic [CW-1:0] CNT_LAST = CW'((RAM_SIZE / 4) - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{CW{1'b1}}, {WORD_OFFSET_W{1'b0}}};
    localparam state_e RESET_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    state_e          state_r, state_nxt_s;
    logic [CW-1:0]   cnt_r, cnt_nxt_s;
    logic            fill_s, run_s;
    logic [1:0]      gnt_s;
    port_id_t        gnt_id_s;
    logic            gnt_valid_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic            rvalid_r, rwe_r;
    port_id_t        rid_r;

    // Outputs are gated by rstn_i so nothing is driven while reset is held.
    assign fill_s      = (state_r == ST_INIT) && rstn_i;
    assign run_s       = (state_r == ST_RUN) && rstn_i;
    assign init_done_o = (state_r == ST_RUN);

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .en_i        (run_s),
        .req_i       ({p1_req_i, p0_req_i}),
        .gnt_o       (gnt_s),
        .gnt_id_o    (gnt_id_s),
        .gnt_valid_o (gnt_valid_s)
    );

    assign p0_gnt_o = gnt_s[0];
    assign p1_gnt_o = gnt_s[1];

    // Next-state logic: walk the fill counter, then settle in RUN.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_INIT: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = {CW{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end
            ST_RUN: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s = RESET_STATE;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

    // FSM state and fill counter registers.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= RESET_STATE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // RAM request mux: fill writes during INIT, the winner's access in RUN.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        sel_addr_s  = {ADDR_WIDTH{1'b0}};
        ram_be_o    = {BW{1'b0}};
        ram_wdata_o = {DATA_WIDTH{1'b0}};
        if (fill_s) begin
            ram_en_o   = 1'b1;
            ram_we_o   = 1'b1;
            sel_addr_s = {cnt_r, {WORD_OFFSET_W{1'b0}}};
            ram_be_o   = {BW{1'b1}};
        end else if (gnt_valid_s) begin
            ram_en_o = 1'b1;
            if (gnt_id_s == PORT1) begin
                ram_we_o    = p1_we_i;
                sel_addr_s  = p1_addr_i;
                ram_be_o    = p1_be_i;
                ram_wdata_o = p1_wdata_i;
            end else begin
                ram_we_o    = p0_we_i;
                sel_addr_s  = p0_addr_i;
                ram_be_o    = p0_be_i;
                ram_wdata_o = p0_wdata_i;
            end
        end else begin
            ram_en_o = 1'b0;
            ram_we_o = 1'b0;
        end
    end

    // Word-align: the RAM only ever sees whole-word addresses.
    assign ram_addr_o = sel_addr_s & WORD_MASK;

    // Response tracking: remember who was granted and whether it was a read.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rvalid_r <= 1'b0;
            rid_r    <= PORT0;
            rwe_r    <= 1'b0;
        end else begin
            rvalid_r <= gnt_valid_s;
            rid_r    <= gnt_id_s;
            rwe_r    <= gnt_valid_s && ram_we_o;
        end
    end

    assign p0_rvalid_o = rvalid_r && (rid_r == PORT0);
    assign p1_rvalid_o = rvalid_r && (rid_r == PORT1);
    assign p0_rdata_o  = (p0_rvalid_o && !rwe_r) ? ram_rdata_i : {DATA_WIDTH{1'b0}};
    assign p1_rdata_o  = (p1_rvalid_o && !rwe_r) ? ram_rdata_i : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_sp_ram_arbiter.sv
module tb_sp_ram_arbiter;

    localparam int AW    = 15;
    localparam int WORDS = 8192;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        p0_req_i, p0_we_i, p1_req_i, p1_we_i;
    logic [AW-1:0] p0_addr_i, p1_addr_i;
    logic [3:0]  p0_be_i, p1_be_i;
    logic [31:0] p0_wdata_i, p1_wdata_i;
    logic        p0_gnt_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic        ram_en_o, ram_we_o, init_done_o;
    logic [AW-1:0] ram_addr_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sp_ram_arbiter dut (
        .clk(clk), .rstn_i(rstn_i),
        .p0_req_i(p0_req_i), .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o),
        .p0_addr_i(p0_addr_i), .p0_we_i(p0_we_i), .p0_be_i(p0_be_i),
        .p0_wdata_i(p0_wdata_i), .p0_rdata_o(p0_rdata_o),
        .p1_req_i(p1_req_i), .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o),
        .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i), .p1_be_i(p1_be_i),
        .p1_wdata_i(p1_wdata_i), .p1_rdata_o(p1_rdata_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
        .init_done_o(init_done_o)
    );

    // Single-port RAM with 1-cycle read latency; starts with garbage contents.
    logic [31:0] mem [0:WORDS-1];
    logic        seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= $urandom;
            seeded <= 1'b1;
        end else if (ram_en_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) mem[ram_addr_o[AW-1:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
            end else begin
                ram_rdata_i <= mem[ram_addr_o[AW-1:2]];
            end
        end
    end

    // Reference model: expected memory image, round-robin memory, pending response.
    logic [31:0] exp_mem [0:WORDS-1];
    logic        ref_run, ref_last;
    logic        pend_valid, pend_id, pend_we;
    logic [31:0] pend_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ref_reset();
        ref_run    = 1'b0;
        ref_last   = 1'b1;
        pend_valid = 1'b0;
        pend_id    = 1'b0;
        pend_we    = 1'b0;
        pend_data  = 32'h0;
    endtask

    // Check the current cycle against the model, then advance the model.
    task automatic eval();
        logic win, g0, g1, we;
        logic [AW-1:0] a;
        logic [3:0] be;
        logic [31:0] wd;
        win = 1'b0;
        if (p0_req_i && p1_req_i) win = ~ref_last;
        else if (p1_req_i) win = 1'b1;
        g0 = ref_run && p0_req_i && !win;
        g1 = ref_run && p1_req_i && win;
        chk("gnt0", p0_gnt_o, g0);
        chk("gnt1", p1_gnt_o, g1);
        chk("init_done", init_done_o, ref_run);
        chk("rvalid0", p0_rvalid_o, pend_valid && !pend_id);
        chk("rvalid1", p1_rvalid_o, pend_valid && pend_id);
        chk("rdata0", p0_rdata_o, (pend_valid && !pend_id && !pend_we) ? pend_data : 32'h0);
        chk("rdata1", p1_rdata_o, (pend_valid && pend_id && !pend_we) ? pend_data : 32'h0);
        we = win ? p1_we_i : p0_we_i;
        a  = win ? p1_addr_i : p0_addr_i;
        be = win ? p1_be_i : p0_be_i;
        wd = win ? p1_wdata_i : p0_wdata_i;
        if (g0 || g1) begin
            chk("ram_en", ram_en_o, 1'b1);
            chk("ram_we", ram_we_o, we);
            chk("ram_addr", ram_addr_o, (a / 4) * 4);
            chk("ram_be", ram_be_o, be);
            chk("ram_wdata", ram_wdata_o, wd);
            pend_valid = 1'b1;
            pend_id    = win;
            pend_we    = we;
            ref_last   = win;
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) exp_mem[a / 4][8*b +: 8] = wd[8*b +: 8];
            end else begin
                pend_data = exp_mem[a / 4];
            end
        end else begin
            chk("ram_en_idle", ram_en_o, 1'b0);
            chk("ram_we_idle", ram_we_o, 1'b0);
            pend_valid = 1'b0;
        end
    endtask

    task automatic do_cycle(input logic r0, input logic w0, input logic [AW-1:0] a0,
                            input logic [3:0] b0, input logic [31:0] d0,
                            input logic r1, input logic w1, input logic [AW-1:0] a1,
                            input logic [3:0] b1, input logic [31:0] d1);
        @(negedge clk);
        p0_req_i = r0; p0_we_i = w0; p0_addr_i = a0; p0_be_i = b0; p0_wdata_i = d0;
        p1_req_i = r1; p1_we_i = w1; p1_addr_i = a1; p1_be_i = b1; p1_wdata_i = d1;
        #1;
        eval();
    endtask

    task automatic p0_op(input logic w, input logic [AW-1:0] a, input logic [3:0] b, input logic [31:0] d);
        do_cycle(1'b1, w, a, b, d, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
    endtask

    task automatic p1_op(input logic w, input logic [AW-1:0] a, input logic [3:0] b, input logic [31:0] d);
        do_cycle(1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b1, w, a, b, d);
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
    endtask

    // Called at a negedge just after reset release; returns at negedge+1 of the first RUN cycle.
    task automatic run_init();
        int n, bad;
        n = 0;
        bad = 0;
        #1;
        while (!init_done_o && n < 9000) begin
            if (ram_en_o !== 1'b1 || ram_we_o !== 1'b1 || ram_be_o !== 4'hF ||
                ram_wdata_o !== 32'h0 || ram_addr_o !== AW'(n * 4) ||
                p0_gnt_o !== 1'b0 || p1_gnt_o !== 1'b0 || p0_rvalid_o !== 1'b0)
                bad++;
            n++;
            @(negedge clk);
            #1;
        end
        chk("init_len", n, 8192);
        chk("init_seq", bad, 0);
        for (int i = 0; i < WORDS; i++) exp_mem[i] = 32'h0;
        ref_run = 1'b1;
    endtask

    initial begin
        logic [3:0] pat;
        rstn_i = 1'b0;
        p0_req_i = 1'b0; p0_we_i = 1'b0; p0_addr_i = '0; p0_be_i = '0; p0_wdata_i = '0;
        p1_req_i = 1'b0; p1_we_i = 1'b0; p1_addr_i = '0; p1_be_i = '0; p1_wdata_i = '0;
        ref_reset();
        #3;
        chk("rst_init_done", init_done_o, 1'b0);
        chk("rst_ram_en", ram_en_o, 1'b0);
        chk("rst_ram_we", ram_we_o, 1'b0);
        chk("rst_rvalid", {p0_rvalid_o, p1_rvalid_o}, 2'b00);
        chk("rst_rdata", p0_rdata_o | p1_rdata_o, 32'h0);

        // p0 holds a read of word 0 through the whole fill.
        p0_req_i = 1'b1;
        @(negedge clk);
        rstn_i = 1'b1;
        run_init();
        eval();                       // first RUN cycle: p0 granted at once

        p0_op(1'b0, 15'h7FFC, 4'hF, 32'h0);
        idle();
        chk("read_7ffc", p0_rdata_o, 32'h0);

        p0_op(1'b1, 15'h0100, 4'hF, 32'hDEADBEEF);
        p0_op(1'b0, 15'h0100, 4'h0, 32'h0);
        idle();
        chk("rd_100", p0_rdata_o, 32'hDEADBEEF);
        chk("rd_100_p1_quiet", p1_rvalid_o, 1'b0);

        p0_op(1'b1, 15'h0204, 4'hF, 32'h11223344);
        p1_op(1'b1, 15'h0204, 4'b0010, 32'h0000AB00);
        p1_op(1'b0, 15'h0206, 4'h0, 32'h0);     // unaligned address lands on 0x204
        pat = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 1'b0, 15'h0100, 4'h0, 32'h0, 1'b1, 1'b0, 15'h0204, 4'h0, 32'h0);
            if (i == 0) chk("rmw_data", p1_rdata_o, 32'h1122AB44);
            pat[i] = p1_gnt_o;
        end
        chk("alternate", pat, 4'b1010);
        idle();

        // Random traffic over a small window so reads hit earlier writes.
        for (int i = 0; i < 400; i++) begin
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)),
                     4'($urandom), $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)),
                     4'($urandom), $urandom);
        end
        idle();

        // Reset with a read in flight: its response must never appear.
        @(negedge clk);
        p0_req_i = 1'b1; p0_we_i = 1'b0; p0_addr_i = 15'h0100;
        p1_req_i = 1'b0;
        #1;
        eval();
        #2;
        rstn_i = 1'b0;
        p0_req_i = 1'b0;
        ref_reset();
        @(negedge clk);
        #1;
        chk("rst_pend_rvalid", p0_rvalid_o, 1'b0);
        chk("rst_pend_rdata", p0_rdata_o, 32'h0);
        chk("rst_gnt", {p0_gnt_o, p1_gnt_o}, 2'b00);
        chk("rst2_init_done", init_done_o, 1'b0);

        // Reset in the middle of the fill restarts it from word 0.
        @(negedge clk);
        rstn_i = 1'b1;
        repeat (3000) @(negedge clk);
        #1;
        chk("mid_init_addr", ram_addr_o, AW'(3000 * 4));
        rstn_i = 1'b0;
        #1;
        chk("mid_rst_ram_en", ram_en_o, 1'b0);
        @(negedge clk);
        rstn_i = 1'b1;
        run_init();
        p0_op(1'b0, 15'h0100, 4'h0, 32'h0);
        idle();
        chk("refill_100", p0_rdata_o, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sp_ram_arbiter.md
SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
REQ-001 SHALL have parameter RAM_SIZE, default 32768, meaning RAM capacity in bytes.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(RAM_SIZE), meaning byte-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning word width.
REQ-004 SHALL have parameter INIT_EN, default 1, meaning zero-fill the RAM after reset when 1.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port rstn_i, input, 1, reset (asynchronous, active-low).
REQ-007 SHALL have, for N in {0,1}, ports pN_req_i (in, 1), pN_gnt_o (out, 1), pN_rvalid_o (out, 1), pN_addr_i (in, ADDR_WIDTH), pN_we_i (in, 1), pN_be_i (in, DATA_WIDTH/8), pN_wdata_i (in, DATA_WIDTH), pN_rdata_o (out, DATA_WIDTH); these form requester port N (port 0 = core LSU, port 1 = debug/AXI).
REQ-008 SHALL have RAM-side ports ram_en_o, ram_we_o (out, 1), ram_addr_o (out, ADDR_WIDTH), ram_be_o (out, DATA_WIDTH/8), ram_wdata_o (out, DATA_WIDTH) and ram_rdata_i (in, DATA_WIDTH); these connect to a single-port RAM with 1-cycle read latency.
REQ-009 SHALL have init_done_o, out, 1, high once the RAM is available to requesters.

Function
REQ-010 SHALL implement FSM states INIT and RUN; reset state SHALL be INIT if INIT_EN=1, else RUN.
REQ-011 In INIT, the word counter SHALL advance from 0 to RAM_SIZE/4-1, one word per cycle, driving ram_en_o=1, ram_we_o=1, ram_be_o all-ones, ram_wdata_o=0, ram_addr_o={counter,2'b00}.
REQ-012 In INIT, both gnt outputs SHALL be 0 regardless of req.
REQ-013 After the cycle that writes the last word, the FSM SHALL enter RUN, and init_done_o SHALL be 1 from that cycle onward.
REQ-014 In RUN, grant SHALL be combinational: pN_gnt_o is asserted in the same cycle as pN_req_i when port N wins.
REQ-015 Only one gnt SHALL be high per cycle.
REQ-016 With a single requester, that requester SHALL be granted.
REQ-017 With both requesting, the port not granted most recently SHALL win (round-robin).
REQ-018 The last-grant pointer SHALL reset to port 1, so port 0 wins the first tie.
REQ-019 The last-grant pointer SHALL update only on a granted cycle.
REQ-020 In a granted cycle, ram_en_o=1, and ram_we_o, ram_be_o, ram_wdata_o SHALL be the winner's values.
REQ-021 In a granted cycle, ram_addr_o SHALL be the winner's address with bits [1:0] forced to 0.
REQ-022 With no grant, ram_en_o=0 and ram_we_o=0.
REQ-023 pN_rvalid_o SHALL pulse exactly one cycle after each grant to port N, for both reads and writes.
REQ-024 pN_rdata_o SHALL equal ram_rdata_i when pN_rvalid_o=1 after a read, and 0 otherwise.
REQ-025 Routing of read data SHALL use a registered grant-id and valid flag, not current request inputs.
REQ-026 Back-to-back grants, to the same or alternating ports, SHALL be sustained at one transaction per cycle.
REQ-027 A request deasserted before grant SHALL be dropped without side effects.

Reset
REQ-028 On rstn_i low, all of the following SHALL clear asynchronously: FSM, counter, last-grant pointer, and the rvalid/grant-id registers.
REQ-029 Reset values: all gnt and rvalid outputs 0, rdata 0, init_done_o = !INIT_EN, and ram_en_o/ram_we_o 0.
REQ-030 Reset asserted mid-INIT SHALL restart the fill from word 0 on release.
REQ-031 Reset asserted with a read pending SHALL suppress that read's rvalid.

Structure
REQ-032 The FSM state enum and the port-id type SHALL reside in shared package sp_ram_pkg.
REQ-033 Round-robin grant logic SHALL be sub-module rr_arb2 (2-input, combinational grant plus last-grant register).
REQ-034 The block SHALL instantiate no RAM; it drives sp_ram_wrap from its parent.

Verification
REQ-035 Reset release with INIT_EN=1 -> init_done_o rises after exactly 8192 cycles; a read of 0x7FFC then returns 0x00000000.
REQ-036 p0 write 0x100 data 0xDEADBEEF be=4'b1111, then p0 read 0x100 -> p0_rvalid_o one cycle later with rdata 0xDEADBEEF; p1_rvalid_o stays 0.
REQ-037 p0 and p1 both hold req for 4 cycles -> grants alternate p0,p1,p0,p1, with one rvalid per cycle to the matching port.
REQ-038 p1 write 0x204 be=4'b0010 data 0x0000AB00 over existing 0x11223344 -> a subsequent read returns 0x1122AB44.
REQ-039 p0 req during INIT -> no gnt until init_done_o=1; granted in the first RUN cycle.
REQ-040 rstn_i pulsed low at INIT word 3000 -> counter restarts at 0, and init_done_o rises 8192 cycles after release.
